// File: rtl/ldl_sfifo_wr_arb_pkg.sv
// Shared types and helpers for the LDL sync-FIFO write arbiter.
package ldl_sfifo_wr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Round-robin successor of idx among n slots; wraps by compare so any n is legal.
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    nxt = idx + 32'd1;
    return (nxt >= n) ? 32'd0 : nxt;
  endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning from ptr upward (mod N).
// Reusable by other LDL arbiters; ptr must be below N.
module ldl_rr_pick #(
  parameter int N = 4,
  localparam int IW = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest candidate back to ptr so the nearest hit is written last and wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      int  c;
      logic hit;
      c       = int'(ptr_i) + k;
      c       = (c >= N) ? c - N : c;
      hit     = req_i[c];
      found_o = found_o | hit;
      idx_o   = hit ? IW'(c) : idx_o;
    end
  end

endmodule

// File: rtl/ldl_sfifo_wr_arb.sv
// Packet-aware round-robin write arbiter sharing one sync-FIFO write port among N requesters.
// A granted requester keeps the port until its last-flagged beat, so packets never interleave.
// Optional per-requester accepted-beat counters are built when LDL_WRARB_STATS_EN is defined.
module ldl_sfifo_wr_arb
  import ldl_sfifo_wr_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16,
  localparam int IW    = ($clog2(N) > 0) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      req_last,
  input  logic [N*DWIDTH-1:0] din,
  output logic [N-1:0]      gnt,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [DWIDTH-1:0] fifo_wdata,
  output logic              busy,
  output logic [IW-1:0]     owner
`ifdef LDL_WRARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [N*CWIDTH-1:0] stat_cnt
`endif
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;

  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic [IW-1:0] sel_s;
  logic          accept_s;
  logic          last_s;

  ldl_rr_pick #(.N(N)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  // Select the serving index, qualify the grant and steer the write port.
  always_comb begin
    sel_s      = (state_q == LOCK) ? owner_q : pick_idx_s;
    // rst_n gates the grant so nothing reaches the FIFO while reset is held.
    accept_s   = rst_n & ~fifo_full & req[sel_s] & ((state_q == LOCK) | pick_found_s);
    last_s     = req_last[sel_s];
    gnt        = {N{1'b0}};
    gnt[sel_s] = accept_s;
    fifo_we    = accept_s;
    fifo_wdata = din[sel_s*DWIDTH +: DWIDTH];
    busy       = (state_q == LOCK);
    owner      = owner_q;
  end

  // Next-state logic: state, owner and rr_ptr move only on an accepted beat.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          owner_d = sel_s;
          if (last_s) begin
            rr_ptr_d = IW'(rr_next(32'(sel_s), 32'(N)));
          end else begin
            state_d = LOCK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (accept_s && last_s) begin
          state_d  = IDLE;
          rr_ptr_d = IW'(rr_next(32'(owner_q), 32'(N)));
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration state registers; reset abandons any packet in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= {IW{1'b0}};
      owner_q  <= {IW{1'b0}};
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef LDL_WRARB_STATS_EN
  logic [N*CWIDTH-1:0] stat_q, stat_d;

  // Saturating per-requester beat counters; clear wins over increment.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < N; i++) begin
      if (stat_clr) begin
        stat_d[i*CWIDTH +: CWIDTH] = {CWIDTH{1'b0}};
      end else if (gnt[i] && (stat_q[i*CWIDTH +: CWIDTH] != {CWIDTH{1'b1}})) begin
        stat_d[i*CWIDTH +: CWIDTH] = stat_q[i*CWIDTH +: CWIDTH] + {{(CWIDTH-1){1'b0}}, 1'b1};
      end else begin
        stat_d[i*CWIDTH +: CWIDTH] = stat_q[i*CWIDTH +: CWIDTH];
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= {(N*CWIDTH){1'b0}};
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`else
  logic [31:0] unused_cwidth_s;
  assign unused_cwidth_s = 32'(CWIDTH);
`endif

endmodule

// File: tb/tb_ldl_sfifo_wr_arb.sv
// Directed self-checking bench for ldl_sfifo_wr_arb (N=4, DWIDTH=32, CWIDTH=4).
// Stats checks are compiled in only when LDL_WRARB_STATS_EN is defined.
module tb_ldl_sfifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] din;
  logic [N-1:0]    gnt;
  logic            fifo_full;
  logic            fifo_we;
  logic [DW-1:0]   fifo_wdata;
  logic            busy;
  logic [1:0]      owner;
`ifdef LDL_WRARB_STATS_EN
  logic            stat_clr;
  logic [N*CW-1:0] stat_cnt;
`endif

  int chk_cnt;
  int pass_cnt;

  ldl_sfifo_wr_arb #(.N(N), .DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_last   (req_last),
    .din        (din),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .owner      (owner)
`ifdef LDL_WRARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_cnt   (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dval(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle point for sampling combinational outputs, mid-cycle.
  task automatic settle();
    #2;
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    int         rr_idx [5];
    chk_cnt  = 0;
    pass_cnt = 0;
    for (int i = 0; i < N; i++) din[i*DW +: DW] = dval(i);
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rr_idx[0] = 0; rr_idx[1] = 1; rr_idx[2] = 2; rr_idx[3] = 3; rr_idx[4] = 0;

    // Reset held with every requester asking.
    rst_n     = 1'b0;
    req       = 4'hF;
    req_last  = 4'hF;
    fifo_full = 1'b0;
`ifdef LDL_WRARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    tick();
    tick();
    settle();
    check("rst_gnt",   32'(gnt),     32'h0);
    check("rst_we",    32'(fifo_we), 32'h0);
    check("rst_busy",  32'(busy),    32'h0);
    check("rst_owner", 32'(owner),   32'h0);

    // Release: round robin over single-beat packets, starting at req0.
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("rr_gnt",   32'(gnt),     32'(rr_exp[c]));
      check("rr_we",    32'(fifo_we), 32'h1);
      check("rr_wdata", fifo_wdata,   dval(rr_idx[c]));
      tick();
    end

    // Packet lock: rr_ptr is 1, req1 sends 3 beats while req2 keeps asking.
    req      = 4'b0110;
    req_last = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) req_last = 4'b0110;
      settle();
      check("lock_gnt",   32'(gnt),    32'h2);
      check("lock_wdata", fifo_wdata,  dval(1));
      check("lock_busy",  32'(busy),   (b == 0) ? 32'h0 : 32'h1);
      tick();
    end
    settle();
    check("lock_next_gnt",  32'(gnt),  32'h4);
    check("lock_next_busy", 32'(busy), 32'h0);
    tick();

    // Full stall mid-packet: req3 opens a packet (rr_ptr is 3).
    req      = 4'b1000;
    req_last = 4'b0000;
    settle();
    check("stall_start_gnt", 32'(gnt), 32'h8);
    tick();
    req       = 4'b1001;
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle();
      check("stall_gnt",   32'(gnt),     32'h0);
      check("stall_we",    32'(fifo_we), 32'h0);
      check("stall_busy",  32'(busy),    32'h1);
      check("stall_owner", 32'(owner),   32'h3);
      tick();
    end
    fifo_full = 1'b0;
    settle();
    check("resume_gnt",   32'(gnt),   32'h8);
    check("resume_wdata", fifo_wdata, dval(3));
    tick();

    // Owner gap: owner 3 drops req for 2 cycles while req0 asks.
    req = 4'b0001;
    for (int g = 0; g < 2; g++) begin
      settle();
      check("gap_gnt",  32'(gnt),     32'h0);
      check("gap_we",   32'(fifo_we), 32'h0);
      check("gap_busy", 32'(busy),    32'h1);
      tick();
    end
    req      = 4'b1001;
    req_last = 4'b1000;
    settle();
    check("gap_last_gnt", 32'(gnt), 32'h8);
    tick();
    settle();
    check("gap_after_gnt",  32'(gnt),  32'h1);
    check("gap_after_busy", 32'(busy), 32'h0);

    // req_last without req is ignored; nothing is accepted.
    req      = 4'b0000;
    req_last = 4'b1111;
    settle();
    check("idle_we", 32'(fifo_we), 32'h0);
    tick();
    settle();
    check("idle_busy", 32'(busy), 32'h0);

`ifdef LDL_WRARB_STATS_EN
    // Clear, then 20 single-beat packets from req0 saturate its 4-bit counter.
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    settle();
    check("stat_clr0", 32'(stat_cnt[3:0]), 32'h0);
    req      = 4'b0001;
    req_last = 4'b0001;
    for (int k = 0; k < 20; k++) tick();
    settle();
    check("stat_sat0", 32'(stat_cnt[3:0]), 32'hF);
    check("stat_cnt1", 32'(stat_cnt[7:4]), 32'h0);
    stat_clr = 1'b1;
    settle();
    check("stat_clr_acc_gnt", 32'(gnt), 32'h1);
    tick();
    stat_clr = 1'b0;
    req      = 4'b0000;
    settle();
    check("stat_clr_acc", 32'(stat_cnt[3:0]), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
